// File: rtl/usr_pkg.sv
// usr_pkg: mode encodings, FSM states and mode classification for the universal shift register
package usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic logic is_shift(input logic [2:0] m);
    return m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR};
  endfunction
endpackage

// File: rtl/universal_shift_reg_n_if.sv
// universal_shift_reg_n_if: control, data and status bundle of the universal shift register
interface universal_shift_reg_n_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] par_in;
  logic             sr_in;
  logic             sl_in;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             sr_out;
  logic             sl_out;
  logic             busy;
  logic             done;
  modport master (output en, mode, par_in, sr_in, sl_in, start, amt,
                  input q, sr_out, sl_out, busy, done);
  modport slave (input en, mode, par_in, sr_in, sl_in, start, amt,
                 output q, sr_out, sl_out, busy, done);
endinterface

// File: rtl/usr_step.sv
// usr_step: one shift/rotate/load step of the register, shared by single-step and run paths
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] nxt
);
  // next register value for the selected mode; reserved code holds
  always_comb begin
    nxt = q;
    case (mode)
      MODE_SHR:  nxt = {sr_in, q[WIDTH-1:1]};
      MODE_SHL:  nxt = {q[WIDTH-2:0], sl_in};
      MODE_LOAD: nxt = par_in;
      MODE_ROR:  nxt = {q[0], q[WIDTH-1:1]};
      MODE_ROL:  nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ASR:  nxt = {q[WIDTH-1], q[WIDTH-1:1]};
      default:   nxt = q;
    endcase
  end
endmodule

// File: rtl/universal_shift_reg_n.sv
// universal_shift_reg_n: parametrised universal shift register with a multi-step shift engine
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  universal_shift_reg_n_if.slave bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       run_mode_q, run_mode_d;
  logic [WIDTH-1:0] data_q, data_d, step_q;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       step_mode;
  assign step_mode = (state_q == ST_RUN) ? run_mode_q : bus.mode;
  usr_step #(.WIDTH(WIDTH)) u_step (
    .q      (data_q),
    .mode   (step_mode),
    .sr_in  (bus.sr_in),
    .sl_in  (bus.sl_in),
    .par_in (bus.par_in),
    .nxt    (step_q)
  );
  // FSM: idle accepts start (priority) or a single step; run steps the latched mode until the count expires
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_mode_d = run_mode_q;
    data_d     = data_q;
    done_d     = 1'b0;
    if (state_q == ST_RUN) begin
      data_d = step_q;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (bus.start && is_shift(bus.mode)) begin
      run_mode_d = bus.mode;
      cnt_d      = bus.amt;
      state_d    = (bus.amt != '0) ? ST_RUN : ST_IDLE;
      done_d     = (bus.amt == '0);
    end else if (bus.en) begin
      data_d = step_q;
    end
    busy_d = (state_d == ST_RUN);
  end
  // state, counter, data and status registers; reset aborts any run without a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      run_mode_q <= MODE_HOLD;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_mode_q <= run_mode_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign bus.q      = data_q;
  assign bus.sr_out = data_q[0];
  assign bus.sl_out = data_q[WIDTH-1];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: doc/universal_shift_reg_n.md
Name: universal_shift_reg_n

Overview:
- Parametrised next-generation universal shift register. Width is configurable and rotate and arithmetic-shift modes are added.
- Adds a multi-step shift engine: one start command performs N single-bit shift/rotate steps over N cycles, with busy/done handshake.
- Used as a serialiser/deserialiser and barrel-shift substitute in datapath blocks that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, 4, width of amt and of the step counter. Must satisfy CNT_W >= $clog2(WIDTH)+1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- en  input  1  single-step enable, sampled in IDLE only.
- mode  input  3  operation select (see Behaviour).
- par_in  input  WIDTH  parallel load data.
- sr_in  input  1  serial input entering at MSB on right shift.
- sl_in  input  1  serial input entering at LSB on left shift.
- start  input  1  multi-step request, sampled in IDLE only.
- amt  input  CNT_W  number of steps for start.
- q  output  WIDTH  register contents.
- sr_out  output  1  q[0], the bit leaving on right shift.
- sl_out  output  1  q[WIDTH-1], the bit leaving on left shift.
- busy  output  1  multi-step run in progress.
- done  output  1  one-cycle pulse after a run completes.

Behaviour:
- Reset (async, reset=0):
  - q=0, busy=0, done=0, state=IDLE, counter=0.
  - Takes effect mid-run; any run in progress is aborted with no done pulse.
- Mode encodings, all applied per step at the clock edge:
  - 000 hold.
  - 001 SHR: q <= {sr_in, q[WIDTH-1:1]}.
  - 010 SHL: q <= {q[WIDTH-2:0], sl_in}.
  - 011 LOAD: q <= par_in.
  - 100 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 101 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}.
  - 111 reserved, acts as hold.
- sr_out and sl_out are combinational from q and have no added latency.
- IDLE priority: start over en.
  - start=1 with a shifting mode (001, 010, 100, 101, 110):
    - mode and amt are latched and q is NOT changed on this edge.
    - amt!=0: go to RUN with counter=amt; busy=1 from the next cycle.
    - amt=0: stay in IDLE and pulse done=1 on the next cycle; busy is never asserted.
  - start=1 with mode 000/011/111: start is ignored and the edge is treated as a single step gated by en.
  - start=0, en=1: one step of the current mode; q updates on this edge (1-cycle latency).
  - start=0, en=0: hold.
- RUN:
  - Each edge performs one step of the latched mode and decrements the counter.
  - sr_in/sl_in are sampled live every cycle, so streamed serial data is allowed.
  - On the edge where counter==1: the final step is taken, state goes to IDLE, busy drops to 0 and done=1 for exactly one cycle.
  - The final q is therefore valid amt edges after the start edge, and busy is high for exactly amt cycles.
  - start, en and mode are ignored while busy=1. A new start is accepted in the cycle done is high, because the state is already IDLE.
- amt > WIDTH is legal:
  - Rotates wrap modulo WIDTH.
  - SHR/SHL fully flush the register with serial input.
  - ASR saturates to all copies of the sign bit.
- All outputs are registered, except sr_out and sl_out.

Decomposition:
- Package usr_pkg: mode encoding constants (MODE_HOLD … MODE_ASR) and FSM state constants (ST_IDLE, ST_RUN).
- Sub-module usr_step: a combinational next-value unit taking (q, mode, sr_in, sl_in) and returning next q. It is shared by the single-step and RUN paths and is unit-tested separately.
- The top level holds the FSM, counter, q register and done/busy flops.

Test Plan (WIDTH=8, CNT_W=4):
- Load then shift:
  - mode=011, en=1, par_in=8'hA5 -> q=8'hA5, sr_out=1, sl_out=1.
  - Then mode=001, sr_in=1 -> q=8'hD2.
- Multi-step rotate: q=8'h81, start=1, mode=101, amt=3:
  - busy=1 for 3 cycles, q steps 8'h03, 8'h06, 8'h0C.
  - done=1 for one cycle as busy falls, q=8'h0C.
- Arithmetic shift: q=8'h90, start, mode=110, amt=2 -> q=8'hC8 then 8'hE4, then done.
- amt=0 and ignored start:
  - start with amt=0 -> done pulses next cycle, busy stays 0, q unchanged.
  - A start issued while busy=1 is ignored: exactly one done pulse, q reflects only the first run.
- Left-shift fill: q=8'h00, sl_in=1, start, mode=010, amt=8 -> q=8'hFF after 8 steps. Separately, mode=111 with en=1 holds q.
- Reset mid-run: during a run with amt=6, reset=0 after 2 steps -> q=8'h00, busy=0 immediately (asynchronously), no done pulse. After reset=1, the block is in IDLE and accepts a new start.
